// File: rtl/mmio_timer_resp.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer_resp
// Purpose  : Memory-mapped timer/port responder on the 8-bit CPU data bus.
// Revision : 1.0  initial release
// ============================================================================
module mmio_timer_resp #(
    parameter logic [12:0] BASE = 13'h1FF8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [12:0] ADDR,
    inout  wire  [7:0]  DATA,
    input  logic        RD,
    input  logic        WR,
    output logic [7:0]  PORT_OUT,
    output logic        IRQ
);

    localparam logic [2:0] c_OFF_CTRL    = 3'd0;
    localparam logic [2:0] c_OFF_PRESC   = 3'd1;
    localparam logic [2:0] c_OFF_COMPARE = 3'd2;
    localparam logic [2:0] c_OFF_COUNT   = 3'd3;
    localparam logic [2:0] c_OFF_STATUS  = 3'd4;
    localparam logic [2:0] c_OFF_PORT    = 3'd5;

    logic [2:0] r_ctrl;      // [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
    logic [7:0] r_presc;
    logic [7:0] r_compare;
    logic [7:0] r_count;
    logic [1:0] r_status;    // [0] MATCH, [1] OVERRUN
    logic [7:0] r_port;
    logic [7:0] r_pcnt;
    logic       r_wr_q;
    logic       r_rd_q;
    logic       r_rd_stat_q;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr_fire;
    logic       w_wr_ctrl;
    logic       w_wr_presc;
    logic       w_wr_compare;
    logic       w_wr_count;
    logic       w_wr_status;
    logic       w_wr_port;
    logic       w_tick;
    logic       w_match;
    logic       w_rd_clear;
    logic [1:0] w_status_nxt;
    logic [7:0] w_rdata;

    assign w_hit        = (ADDR[12:3] == BASE[12:3]);
    assign w_off        = ADDR[2:0];
    // Only the rising edge of WR commits, so long strobes write once.
    assign w_wr_fire    = WR & ~r_wr_q & w_hit;
    assign w_wr_ctrl    = w_wr_fire & (w_off == c_OFF_CTRL);
    assign w_wr_presc   = w_wr_fire & (w_off == c_OFF_PRESC);
    assign w_wr_compare = w_wr_fire & (w_off == c_OFF_COMPARE);
    assign w_wr_count   = w_wr_fire & (w_off == c_OFF_COUNT);
    assign w_wr_status  = w_wr_fire & (w_off == c_OFF_STATUS);
    assign w_wr_port    = w_wr_fire & (w_off == c_OFF_PORT);

    assign w_tick       = r_ctrl[0] & (r_pcnt == r_presc);
    assign w_match      = w_tick & (r_count == r_compare);
    // Status clears after the read finishes so the bus value stays stable.
    assign w_rd_clear   = r_rd_q & ~RD & r_rd_stat_q;

    always_comb begin
        w_status_nxt = r_status;
        if (w_wr_status) begin
            w_status_nxt = r_status & ~DATA[1:0];
        end
        if (w_rd_clear) begin
            w_status_nxt = 2'b00;
        end
        // Setting takes priority over either clear source.
        if (w_match) begin
            w_status_nxt[0] = 1'b1;
            if (r_status[0]) begin
                w_status_nxt[1] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            c_OFF_CTRL:    w_rdata = {5'b00000, r_ctrl};
            c_OFF_PRESC:   w_rdata = r_presc;
            c_OFF_COMPARE: w_rdata = r_compare;
            c_OFF_COUNT:   w_rdata = r_count;
            c_OFF_STATUS:  w_rdata = {6'b000000, r_status};
            c_OFF_PORT:    w_rdata = r_port;
            default:       w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ctrl      <= 3'b000;
            r_presc     <= 8'h00;
            r_compare   <= 8'hFF;
            r_count     <= 8'h00;
            r_status    <= 2'b00;
            r_port      <= 8'h00;
            r_pcnt      <= 8'h00;
            r_wr_q      <= 1'b0;
            r_rd_q      <= 1'b0;
            r_rd_stat_q <= 1'b0;
        end else begin
            r_wr_q   <= WR;
            r_rd_q   <= RD;
            r_status <= w_status_nxt;
            if (RD) begin
                r_rd_stat_q <= w_hit & (w_off == c_OFF_STATUS);
            end

            if (w_wr_ctrl || w_wr_presc || !r_ctrl[0] || w_tick) begin
                r_pcnt <= 8'h00;
            end else begin
                r_pcnt <= r_pcnt + 8'd1;
            end

            if (w_wr_ctrl) begin
                r_ctrl <= DATA[2:0];
            end else if (w_match && !r_ctrl[1]) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_presc) begin
                r_presc <= DATA;
            end
            if (w_wr_compare) begin
                r_compare <= DATA;
            end
            if (w_wr_port) begin
                r_port <= DATA;
            end

            if (w_wr_count) begin
                r_count <= DATA;
            end else if (w_match) begin
                if (r_ctrl[1]) begin
                    r_count <= 8'h00;
                end
            end else if (w_tick) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // Gating with RST releases the bus immediately on reset assertion.
    assign DATA     = (RST && RD && !WR && w_hit) ? w_rdata : 8'hzz;
    assign PORT_OUT = r_port;
    assign IRQ      = r_status[0] & r_ctrl[2];

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer_resp
// Purpose  : Directed self-checking bench for mmio_timer_resp.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_timer_resp;

    logic        clk;
    logic        rst_n;
    logic [12:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  port_out;
    logic        irq;
    logic        drv;
    logic [7:0]  wdat;
    tri1  [7:0]  data_bus;   // undriven bus reads as FF

    assign data_bus = drv ? wdat : 8'hzz;

    int n_pass  = 0;
    int n_total = 0;

    mmio_timer_resp #(.BASE(13'h1FF8)) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .ADDR     (addr),
        .DATA     (data_bus),
        .RD       (rd),
        .WR       (wr),
        .PORT_OUT (port_out),
        .IRQ      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [12:0] a;
        logic [7:0]  d;
    } vec_t;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdat = d; drv = 1'b1; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; drv = 1'b0;
    endtask

    task automatic do_read(input logic [12:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        #2;
        d = data_bus;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Clock-free read: RD pulses between edges, so no state is touched.
    task automatic peek(input logic [12:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        #1;
        d = data_bus;
        rd = 1'b0;
        #1;
    endtask

    vec_t       vec [26];
    logic [7:0] v;
    logic [7:0] exp_cnt;

    initial begin
        vec[0]  = '{0, 13'h1FF8, 8'h00};
        vec[1]  = '{0, 13'h1FF9, 8'h00};
        vec[2]  = '{0, 13'h1FFA, 8'hFF};
        vec[3]  = '{0, 13'h1FFB, 8'h00};
        vec[4]  = '{0, 13'h1FFC, 8'h00};
        vec[5]  = '{0, 13'h1FFD, 8'h00};
        vec[6]  = '{0, 13'h1FFE, 8'h00};
        vec[7]  = '{0, 13'h1FFF, 8'h00};
        vec[8]  = '{1, 13'h1FF9, 8'h2A};
        vec[9]  = '{0, 13'h1FF9, 8'h2A};
        vec[10] = '{1, 13'h1FFA, 8'h5C};
        vec[11] = '{0, 13'h1FFA, 8'h5C};
        vec[12] = '{1, 13'h1FFB, 8'h7F};
        vec[13] = '{0, 13'h1FFB, 8'h7F};
        vec[14] = '{1, 13'h1FF8, 8'hFE};
        vec[15] = '{0, 13'h1FF8, 8'h06};
        vec[16] = '{1, 13'h1FF8, 8'h00};
        vec[17] = '{1, 13'h1FFE, 8'h99};
        vec[18] = '{0, 13'h1FFE, 8'h00};
        vec[19] = '{1, 13'h1FFF, 8'h77};
        vec[20] = '{0, 13'h1FFF, 8'h00};
        vec[21] = '{1, 13'h0002, 8'h11};
        vec[22] = '{0, 13'h1FFA, 8'h5C};
        vec[23] = '{1, 13'h1FFD, 8'h3C};
        vec[24] = '{0, 13'h1FFD, 8'h3C};
        vec[25] = '{0, 13'h1FF0, 8'hFF};

        rst_n = 1'b0; addr = 13'h1FFB; rd = 1'b0; wr = 1'b0; drv = 1'b0; wdat = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check("reset DATA Z with RD=0", data_bus, 8'hFF);
        check("reset PORT_OUT", port_out, 8'h00);
        check("reset IRQ", {7'd0, irq}, 8'h00);
        rst_n = 1'b1;

        // Register map walk
        for (int i = 0; i < 26; i++) begin
            if (vec[i].is_wr) begin
                do_write(vec[i].a, vec[i].d);
            end else begin
                do_read(vec[i].a, v);
                check($sformatf("vec%0d read %h", i, vec[i].a), v, vec[i].d);
            end
        end

        // Long WR pulse commits once, using data from the first edge
        @(negedge clk);
        addr = 13'h1FFD; wdat = 8'hA5; drv = 1'b1; wr = 1'b1;
        @(negedge clk);
        wdat = 8'h11;
        @(negedge clk);
        @(negedge clk);
        wr = 1'b0; drv = 1'b0;
        check("single commit PORT_OUT", port_out, 8'hA5);
        do_write(13'h0005, 8'h33);
        check("out of window PORT_OUT", port_out, 8'hA5);

        // Auto-reload periodic timer: PRESC=3, COMPARE=2
        do_reset();
        do_write(13'h1FF9, 8'h03);
        do_write(13'h1FFA, 8'h02);
        do_write(13'h1FF8, 8'h07);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            peek(13'h1FFB, v);
            exp_cnt = (k < 4) ? 8'd0 : (k < 8) ? 8'd1 : (k < 12) ? 8'd2 : 8'd0;
            check($sformatf("periodic COUNT clk%0d", k), v, exp_cnt);
            if (k == 11) begin
                check("periodic IRQ before match", {7'd0, irq}, 8'h00);
            end
            if (k == 12) begin
                peek(13'h1FFC, v);
                check("periodic STATUS at match", v, 8'h01);
                check("periodic IRQ at match", {7'd0, irq}, 8'h01);
            end
        end

        // One-shot then a second match without clearing
        do_reset();
        do_write(13'h1FFA, 8'h01);
        do_write(13'h1FF8, 8'h01);
        @(negedge clk);
        peek(13'h1FFB, v);
        check("oneshot COUNT step", v, 8'h01);
        @(negedge clk);
        peek(13'h1FFC, v);
        check("oneshot STATUS", v, 8'h01);
        peek(13'h1FF8, v);
        check("oneshot EN cleared", v, 8'h00);
        @(negedge clk);
        peek(13'h1FFB, v);
        check("oneshot COUNT holds", v, 8'h01);
        do_write(13'h1FF8, 8'h01);
        @(negedge clk);
        peek(13'h1FFC, v);
        check("oneshot overrun STATUS", v, 8'h03);
        do_write(13'h1FFC, 8'h02);
        peek(13'h1FFC, v);
        check("W1C overrun only", v, 8'h01);

        // Read-clear: stable during a 2-cycle read, clears after RD falls
        do_reset();
        do_write(13'h1FFA, 8'h00);
        do_write(13'h1FF8, 8'h01);
        @(negedge clk);
        addr = 13'h1FFC; rd = 1'b1;
        #1;
        check("rdclr DATA cycle0", data_bus, 8'h01);
        @(negedge clk);
        check("rdclr DATA cycle1", data_bus, 8'h01);
        @(negedge clk);
        check("rdclr DATA cycle2", data_bus, 8'h01);
        rd = 1'b0;
        #1;
        peek(13'h1FFC, v);
        check("rdclr STATUS before edge", v, 8'h01);
        @(negedge clk);
        peek(13'h1FFC, v);
        check("rdclr STATUS after edge", v, 8'h00);

        // Set beats read-clear on the same edge
        do_reset();
        do_write(13'h1FFA, 8'h00);
        do_write(13'h1FF8, 8'h03);
        @(negedge clk);
        addr = 13'h1FFC; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        peek(13'h1FFC, v);
        check("set beats clear STATUS", v, 8'h03);
        check("IRQ off without IRQ_EN", {7'd0, irq}, 8'h00);

        // Asynchronous reset mid-read
        do_reset();
        do_write(13'h1FFB, 8'h7F);
        @(negedge clk);
        addr = 13'h1FFB; rd = 1'b1;
        #1;
        check("midreset DATA before", data_bus, 8'h7F);
        rst_n = 1'b0;
        #1;
        check("midreset DATA Z", data_bus, 8'hFF);
        rst_n = 1'b1;
        #1;
        check("midreset COUNT cleared", data_bus, 8'h00);
        rd = 1'b0;

        // COUNT write wins over a coincident tick
        do_reset();
        do_write(13'h1FF8, 8'h03);
        repeat (3) @(negedge clk);
        do_write(13'h1FFB, 8'h40);
        peek(13'h1FFB, v);
        check("write beats tick COUNT", v, 8'h40);
        @(negedge clk);
        peek(13'h1FFB, v);
        check("count resumes after write", v, 8'h41);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
